move_queue: RTL and testbench
=============================

// Module: move_queue
// PURPOSE
//  Move-segment FIFO between the SPI word handler and the DDA step timing engine.
//  - Assembles 4-word coordinated-move messages (header, duration, increment,
//    increment-increment) from the 64-bit SPI word stream into one record.
//  - Queues records in a circular buffer.
//  - Presents the oldest record to the DDA over a valid/ready handshake.
// PARAMETERS
//  MOVE_BUFFER_BITS  2   log2 of queue depth (depth = 2**MOVE_BUFFER_BITS = 4)
// PORTS
//  CLK            in   1   system clock (16 MHz); sole clock
//  resetn         in   1   synchronous, active-low reset
//  word_valid     in   1   one-CLK pulse: word_data holds a newly received SPI word
//  word_data      in   64  received word; header byte = [63:56]
//  move_valid     out  1   queue non-empty; move_* fields hold the oldest record
//  move_ready     in   1   DDA pops the record on a cycle with move_valid & move_ready
//  move_dir       out  1   direction bit of the head record
//  move_duration  out  64  head record tick count (always > 0)
//  move_increment out  64  head record signed initial increment
//  move_incinc    out  64  head record signed increment-increment
//  level          out  MOVE_BUFFER_BITS+1  records stored (0..depth)
//  overflow       out  1   sticky: a completed record was dropped because the queue was full
//  zero_dur       out  1   sticky: a record with duration 0 was dropped
//  clear_status   in   1   one-CLK pulse: clears overflow and zero_dur
// BEHAVIOUR
//  Reset (resetn=0 at a CLK edge):
//   - Pointers, level and FSM return to zero / IDLE.
//   - move_valid=0, overflow=0, zero_dur=0, move_* outputs=0.
//   - Any partial message is discarded; words arriving during reset are ignored.
//  Assembler FSM (advances only on word_valid):
//   IDLE     header==`CMD_COORDINATED_STEP -> latch dir=word_data[0]; go to GET_DUR.
//            Any other header -> ignored; stay in IDLE.
//   GET_DUR  latch duration -> GET_INC
//   GET_INC  latch increment -> GET_II
//   GET_II   latch increment-increment; commit the record -> IDLE
//  Commit rules:
//   - Duration==0: record dropped, zero_dur set; takes priority over the full check.
//   - Full (level==depth) with no pop in the same cycle: record dropped, overflow set.
//   - Full with a pop in the same cycle: commit allowed; level stays at depth.
//   - Otherwise: write at wr_ptr, wr_ptr+1 (wraps mod depth), level+1.
//  Latency: record committed at edge N -> move_valid=1 and fields valid after edge N.
//  Read side (first-word-fall-through):
//   - move_* read combinationally from the slot at rd_ptr.
//   - A pop at edge N advances rd_ptr (wraps) and decrements level.
//   - After edge N the next record is visible, or move_valid=0 if empty.
//   - move_ready while move_valid=0: no effect; level never underflows.
//  Simultaneous commit and pop: level unchanged; both pointers advance.
//  Status flags: clear_status and a same-cycle set -> set wins (flag stays 1).
//  Pointers are MOVE_BUFFER_BITS wide. Full/empty is decided from level, not by
//  pointer compare.
// CONFIGURATION
//  MOVEQ_FLUSH_EN defined:
//   - Adds input flush (1 bit): a one-CLK pulse empties the queue.
//   - rd_ptr := wr_ptr, level := 0, move_valid := 0 on the next edge.
//   - The assembler FSM returns to IDLE; overflow and zero_dur are kept.
//   - flush overrides any same-cycle commit or pop.
//  MOVEQ_FLUSH_EN undefined: no flush port; the queue is emptied only by pops or reset.
// STRUCTURE
//  constants.v (shared): `CMD_COORDINATED_STEP, `MOVE_BUFFER_BITS default, field
//  widths (MOVE_DUR_W=64, MOVE_INC_W=64).
//  Sub-module moveq_ram:
//   - Depth x 193-bit storage (dir + 3x64).
//   - One synchronous write port, one asynchronous read port.
//  move_queue holds the FSM, pointers, level and status.
// TESTING
//  1. Reset, then send header(dir=1), 0x10, 0x5, -0x1 -> one edge after the 4th
//     word: move_valid=1, dir=1, duration=0x10, inc=5, incinc=-1, level=1.
//  2. Send 5 valid moves with move_ready=0 -> level=4; 5th dropped, overflow=1;
//     pop 4 times -> records 1..4 in order, then move_valid=0, level=0.
//  3. Queue full; 4th word of a new move arrives on a pop cycle -> level stays 4,
//     new record is returned after the three older ones.
//  4. Move with duration=0 -> not queued, zero_dur=1, level unchanged;
//     clear_status -> zero_dur=0.
//  5. Send a non-move header (e.g. `CMD_MOTOR_ENABLE) and then 3 data words ->
//     FSM stays in IDLE, level=0. Pull resetn low after 2 words of a move, then
//     send a full move -> only the full move is queued.
//  6. (MOVEQ_FLUSH_EN) With 3 records queued, pulse flush together with move_ready
//     -> level=0, move_valid=0 next edge; the next move is queued in a fresh slot.

Source files
------------

// File: rtl/move_queue_pkg.sv
// Shared constants, assembler state encoding and the queued move record layout
// for move_queue.
package move_queue_pkg;

  localparam int MOVE_DUR_W = 64;
  localparam int MOVE_INC_W = 64;

  localparam logic [7:0] CMD_COORDINATED_STEP = 8'h01;
  localparam logic [7:0] CMD_MOTOR_ENABLE     = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    GET_DUR,
    GET_INC,
    GET_II
  } asm_state_t;

  typedef struct packed {
    logic                  dir;
    logic [MOVE_DUR_W-1:0] duration;
    logic [MOVE_INC_W-1:0] increment;
    logic [MOVE_INC_W-1:0] incinc;
  } move_rec_t;

endpackage

// File: rtl/moveq_ram.sv
// Move record storage: one synchronous write port and one asynchronous read
// port, so the queue head is visible in the same cycle it is addressed.
module moveq_ram
  import move_queue_pkg::*;
#(
  parameter int ADDR_W = 2
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  move_rec_t         wdata,
  input  logic [ADDR_W-1:0] raddr,
  output move_rec_t         rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  move_rec_t mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/move_queue.sv
// Move-segment FIFO: assembles 4-word coordinated-move messages into records,
// queues them and presents the oldest one over valid/ready.
// Optional MOVEQ_FLUSH_EN adds a flush input that empties the queue.
module move_queue
  import move_queue_pkg::*;
#(
  parameter int MOVE_BUFFER_BITS = 2
) (
  input  logic                      CLK,
  input  logic                      resetn,
  input  logic                      word_valid,
  input  logic [63:0]               word_data,
  output logic                      move_valid,
  input  logic                      move_ready,
  output logic                      move_dir,
  output logic [MOVE_DUR_W-1:0]     move_duration,
  output logic [MOVE_INC_W-1:0]     move_increment,
  output logic [MOVE_INC_W-1:0]     move_incinc,
  output logic [MOVE_BUFFER_BITS:0] level,
  output logic                      overflow,
  output logic                      zero_dur,
  input  logic                      clear_status
`ifdef MOVEQ_FLUSH_EN
  ,
  input  logic                      flush
`endif
);

  localparam int DEPTH = 1 << MOVE_BUFFER_BITS;
  localparam logic [MOVE_BUFFER_BITS:0] FULL_LEVEL = (MOVE_BUFFER_BITS+1)'(DEPTH);

  asm_state_t state, state_next;

  logic                        dir_q;
  logic [MOVE_DUR_W-1:0]       dur_q;
  logic [MOVE_INC_W-1:0]       inc_q;
  logic [MOVE_BUFFER_BITS-1:0] wr_ptr, rd_ptr;
  logic [MOVE_BUFFER_BITS:0]   level_q;
  logic                        overflow_q, zero_dur_q;

  logic latch_dir, latch_dur, latch_inc, commit;
  logic full, empty, do_pop, do_write, commit_zero, commit_full;
  logic flush_i;
  move_rec_t wr_rec, head;

`ifdef MOVEQ_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  always_comb begin
    state_next = state;
    latch_dir  = 1'b0;
    latch_dur  = 1'b0;
    latch_inc  = 1'b0;
    commit     = 1'b0;
    if (flush_i) begin
      state_next = IDLE;
    end else if (word_valid) begin
      case (state)
        IDLE: begin
          if (word_data[63:56] == CMD_COORDINATED_STEP) begin
            latch_dir  = 1'b1;
            state_next = GET_DUR;
          end
        end
        GET_DUR: begin
          latch_dur  = 1'b1;
          state_next = GET_INC;
        end
        GET_INC: begin
          latch_inc  = 1'b1;
          state_next = GET_II;
        end
        GET_II: begin
          commit     = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign full  = (level_q == FULL_LEVEL);
  assign empty = (level_q == '0);

  // Zero duration is judged before fullness; a same-cycle pop frees a full slot.
  assign do_pop      = !flush_i && !empty && move_ready;
  assign commit_zero = commit && (dur_q == '0);
  assign do_write    = commit && !commit_zero && (!full || do_pop);
  assign commit_full = commit && !commit_zero && full && !do_pop;

  assign wr_rec = '{dir: dir_q, duration: dur_q, increment: inc_q, incinc: word_data};

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state      <= IDLE;
      dir_q      <= 1'b0;
      dur_q      <= '0;
      inc_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      zero_dur_q <= 1'b0;
    end else begin
      state <= state_next;
      if (latch_dir) dir_q <= word_data[0];
      if (latch_dur) dur_q <= word_data;
      if (latch_inc) inc_q <= word_data;

      if (flush_i) begin
        rd_ptr  <= wr_ptr;
        level_q <= '0;
      end else begin
        if (do_write) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
        case ({do_write, do_pop})
          2'b10:   level_q <= level_q + 1'b1;
          2'b01:   level_q <= level_q - 1'b1;
          default: level_q <= level_q;
        endcase
      end

      overflow_q <= (overflow_q && !clear_status) || commit_full;
      zero_dur_q <= (zero_dur_q && !clear_status) || commit_zero;
    end
  end

  moveq_ram #(
    .ADDR_W(MOVE_BUFFER_BITS)
  ) u_ram (
    .CLK   (CLK),
    .we    (do_write),
    .waddr (wr_ptr),
    .wdata (wr_rec),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Fields are forced to zero while empty so stale storage never leaks out.
  assign move_valid     = !empty;
  assign move_dir       = move_valid & head.dir;
  assign move_duration  = move_valid ? head.duration  : '0;
  assign move_increment = move_valid ? head.increment : '0;
  assign move_incinc    = move_valid ? head.incinc    : '0;
  assign level          = level_q;
  assign overflow       = overflow_q;
  assign zero_dur       = zero_dur_q;

endmodule

// File: tb/tb_move_queue.sv
// Self-checking bench for move_queue: table of moves, directed corner cases and
// randomized traffic against a queue-based reference model.
module tb_move_queue;
  import move_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        resetn = 1'b0;
  logic        word_valid = 1'b0;
  logic [63:0] word_data = '0;
  logic        move_ready = 1'b0;
  logic        clear_status = 1'b0;
  logic        move_valid, move_dir, overflow, zero_dur;
  logic [63:0] move_duration, move_increment, move_incinc;
  logic [2:0]  level;
`ifdef MOVEQ_FLUSH_EN
  logic        flush = 1'b0;
`endif

  always #5 CLK = ~CLK;

  move_queue #(.MOVE_BUFFER_BITS(2)) dut (
    .CLK            (CLK),
    .resetn         (resetn),
    .word_valid     (word_valid),
    .word_data      (word_data),
    .move_valid     (move_valid),
    .move_ready     (move_ready),
    .move_dir       (move_dir),
    .move_duration  (move_duration),
    .move_increment (move_increment),
    .move_incinc    (move_incinc),
    .level          (level),
    .overflow       (overflow),
    .zero_dur       (zero_dur),
    .clear_status   (clear_status)
`ifdef MOVEQ_FLUSH_EN
    ,
    .flush          (flush)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: list of stored records, words of the message in progress.
  move_rec_t   mq[$];
  logic [63:0] msg[$];
  logic        m_ovf = 1'b0;
  logic        m_zd  = 1'b0;

  typedef struct {
    logic        dir;
    logic [63:0] dur;
    logic [63:0] inc;
    logic [63:0] ii;
    int          exp_level;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    chk("model_valid", move_valid, mq.size() != 0);
    chk("model_level", level, mq.size());
    chk("model_overflow", overflow, m_ovf);
    chk("model_zero_dur", zero_dur, m_zd);
    if (mq.size() != 0) begin
      chk("model_dir", move_dir, mq[0].dir);
      chk("model_duration", move_duration, mq[0].duration);
      chk("model_increment", move_increment, mq[0].increment);
      chk("model_incinc", move_incinc, mq[0].incinc);
    end
  endtask

  task automatic cycle(input logic wv, input logic [63:0] wd, input logic rdy,
                       input logic clr, input logic fl);
    logic pop, push, zset, oset;
    move_rec_t nr;
    word_valid   = wv;
    word_data    = wd;
    move_ready   = rdy;
    clear_status = clr;
`ifdef MOVEQ_FLUSH_EN
    flush = fl;
`endif
    pop  = (mq.size() != 0) && rdy && !fl;
    push = 1'b0;
    zset = 1'b0;
    oset = 1'b0;
    nr   = '0;
    if (fl) begin
      msg.delete();
    end else if (wv) begin
      if (msg.size() != 0 || wd[63:56] == CMD_COORDINATED_STEP) msg.push_back(wd);
      if (msg.size() == 4) begin
        nr.dir       = msg[0][0];
        nr.duration  = msg[1];
        nr.increment = msg[2];
        nr.incinc    = msg[3];
        msg.delete();
        if (nr.duration == 0) zset = 1'b1;
        else if (mq.size() == DEPTH && !pop) oset = 1'b1;
        else push = 1'b1;
      end
    end
    if (fl) mq.delete();
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(nr);
    m_ovf = (m_ovf && !clr) || oset;
    m_zd  = (m_zd && !clr) || zset;

    @(posedge CLK);
    #1;
    word_valid   = 1'b0;
    move_ready   = 1'b0;
    clear_status = 1'b0;
`ifdef MOVEQ_FLUSH_EN
    flush = 1'b0;
`endif
    compare_model();
  endtask

  task automatic apply_reset(input logic wv);
    resetn     = 1'b0;
    word_valid = wv;
    word_data  = {CMD_COORDINATED_STEP, 56'h1};
    @(posedge CLK);
    #1;
    resetn     = 1'b1;
    word_valid = 1'b0;
    mq.delete();
    msg.delete();
    m_ovf = 1'b0;
    m_zd  = 1'b0;
    chk("reset_valid", move_valid, 1'b0);
    chk("reset_level", level, 3'd0);
    chk("reset_overflow", overflow, 1'b0);
    chk("reset_zero_dur", zero_dur, 1'b0);
    chk("reset_duration", move_duration, 64'h0);
  endtask

  task automatic send_move(input logic dir, input logic [63:0] dur, input logic [63:0] inc,
                           input logic [63:0] ii, input logic rdy_last);
    cycle(1'b1, {CMD_COORDINATED_STEP, 55'h0, dir}, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, dur, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, inc, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, ii, rdy_last, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [63:0] wd;
    logic [7:0]  hdr;

    tbl[0] = '{1'b1, 64'h11, 64'h1, 64'hA, 1, 1'b0};
    tbl[1] = '{1'b0, 64'h22, 64'hFFFF_FFFF_FFFF_FFFE, 64'hB, 2, 1'b0};
    tbl[2] = '{1'b1, 64'h33, 64'h3, 64'h8000_0000_0000_0000, 3, 1'b0};
    tbl[3] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h4, 64'h0, 4, 1'b0};
    tbl[4] = '{1'b1, 64'h55, 64'h5, 64'h5, 4, 1'b1};

    #2;
    apply_reset(1'b0);

    // Single move, visible one edge after the fourth word.
    send_move(1'b1, 64'h10, 64'h5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    chk("t1_valid", move_valid, 1'b1);
    chk("t1_dir", move_dir, 1'b1);
    chk("t1_duration", move_duration, 64'h10);
    chk("t1_increment", move_increment, 64'h5);
    chk("t1_incinc", move_incinc, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t1_level", level, 3'd1);
    pop_one();
    chk("t1_level_after_pop", level, 3'd0);

    // Fill past capacity, then drain in order.
    for (int i = 0; i < 5; i++) begin
      send_move(tbl[i].dir, tbl[i].dur, tbl[i].inc, tbl[i].ii, 1'b0);
      chk("t2_level", level, tbl[i].exp_level);
      chk("t2_overflow", overflow, tbl[i].exp_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      chk("t2_dir", move_dir, tbl[i].dir);
      chk("t2_duration", move_duration, tbl[i].dur);
      chk("t2_increment", move_increment, tbl[i].inc);
      chk("t2_incinc", move_incinc, tbl[i].ii);
      pop_one();
    end
    chk("t2_valid_empty", move_valid, 1'b0);
    chk("t2_level_empty", level, 3'd0);
    pop_one();
    chk("t2_no_underflow", level, 3'd0);
    cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    chk("t2_overflow_cleared", overflow, 1'b0);

    // Full queue, commit coinciding with a pop.
    for (int i = 0; i < 4; i++) send_move(1'b0, 64'h100 + 64'(i), 64'h1, 64'h2, 1'b0);
    chk("t3_full", level, 3'd4);
    send_move(1'b1, 64'h104, 64'h7, 64'h8, 1'b1);
    chk("t3_level_stays", level, 3'd4);
    chk("t3_no_overflow", overflow, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      chk("t3_order", move_duration, 64'h100 + 64'(i));
      pop_one();
    end
    chk("t3_empty", move_valid, 1'b0);

    // Zero-duration move, then clear; set wins over a same-cycle clear.
    send_move(1'b0, 64'h0, 64'h7, 64'h7, 1'b0);
    chk("t4_zero_dur", zero_dur, 1'b1);
    chk("t4_level", level, 3'd0);
    cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    chk("t4_cleared", zero_dur, 1'b0);
    cycle(1'b1, {CMD_COORDINATED_STEP, 56'h0}, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h9, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h9, 1'b0, 1'b1, 1'b0);
    chk("t4_set_wins", zero_dur, 1'b1);
    cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);

    // Non-move header is ignored along with its data words.
    cycle(1'b1, {CMD_MOTOR_ENABLE, 56'h1}, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h0000_0000_0000_0040, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h0000_0000_0000_0041, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h0000_0000_0000_0042, 1'b0, 1'b0, 1'b0);
    chk("t5_ignored", level, 3'd0);
    send_move(1'b1, 64'h60, 64'h61, 64'h62, 1'b0);
    chk("t5_after_ignore", move_duration, 64'h60);
    pop_one();

    // Reset mid-message discards the partial move.
    cycle(1'b1, {CMD_COORDINATED_STEP, 56'h1}, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h70, 1'b0, 1'b0, 1'b0);
    apply_reset(1'b1);
    send_move(1'b0, 64'h80, 64'h81, 64'h82, 1'b0);
    chk("t5_reset_level", level, 3'd1);
    chk("t5_reset_dur", move_duration, 64'h80);
    chk("t5_reset_inc", move_increment, 64'h81);

`ifdef MOVEQ_FLUSH_EN
    apply_reset(1'b0);
    for (int i = 0; i < 3; i++) send_move(1'b1, 64'h200 + 64'(i), 64'h1, 64'h1, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    chk("t6_flush_level", level, 3'd0);
    chk("t6_flush_valid", move_valid, 1'b0);
    send_move(1'b0, 64'h77, 64'h1, 64'h2, 1'b0);
    chk("t6_fresh_level", level, 3'd1);
    chk("t6_fresh_dur", move_duration, 64'h77);
`endif

    // Randomized traffic against the reference model.
    apply_reset(1'b0);
    for (int n = 0; n < 3000; n++) begin
      if (msg.size() == 0) begin
        hdr = ($urandom_range(0, 3) != 0) ? CMD_COORDINATED_STEP : CMD_MOTOR_ENABLE;
        wd  = {hdr, 24'($urandom), 32'($urandom)};
      end else if (msg.size() == 1 && $urandom_range(0, 7) == 0) begin
        wd = 64'h0;
      end else begin
        wd = {32'($urandom), 32'($urandom)};
      end
      cycle($urandom_range(0, 9) < 6, wd, $urandom_range(0, 2) == 0,
            $urandom_range(0, 19) == 0,
`ifdef MOVEQ_FLUSH_EN
            $urandom_range(0, 49) == 0
`else
            1'b0
`endif
            );
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
